// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared fetch-side definitions for the five-stage CPU: fetch FSM encoding,
// instruction width, PC step and default reset PC.
package instr_prefetch_buffer_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// prefetch_fifo: DEPTH-entry {ir, npc} buffer with push/pop/flush and occupancy.
// Flush and reset clear the pointers; the head reads as zero while empty.
module prefetch_fifo
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch unit: owns the fetch PC, keeps at most one imem read in
// flight, buffers words in prefetch_fifo. Optional macro: INSTR_PREFETCH_BYPASS_EN.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_npc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   req_npc;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          accept, wait_rv, bypass, push, pop;
  logic          room_wait;
  logic          redir_pc_unused;

  assign redir_pc_unused = ^redir_pc[1:0];

  // A new request alongside the returning word must leave room for both.
  assign room_wait = (32'(count) + 32'd1) < DEPTH;

  always_comb begin
    imem_req = 1'b0;
    if (rst && !redir) begin
      case (state)
        FETCH_IDLE: imem_req = !full;
        FETCH_WAIT: imem_req = imem_rvalid && room_wait;
        default:    imem_req = 1'b0;
      endcase
    end
  end

  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign wait_rv   = rst && !redir && (state == FETCH_WAIT) && imem_rvalid;

`ifdef INSTR_PREFETCH_BYPASS_EN
  assign bypass = wait_rv && empty;
`else
  assign bypass = 1'b0;
`endif

  assign push      = wait_rv && !(bypass && out_ready);
  assign pop       = !empty && out_ready && !redir;
  assign wr_entry  = '{ir: imem_rdata, npc: req_npc};

  assign out_valid = !empty || bypass;
  assign out_ir    = bypass ? imem_rdata : head.ir;
  assign out_npc   = bypass ? req_npc    : head.npc;

  always_comb begin
    state_nxt = state;
    if (redir) begin
      case (state)
        FETCH_WAIT:    state_nxt = imem_rvalid ? FETCH_IDLE : FETCH_DISCARD;
        FETCH_DISCARD: state_nxt = imem_rvalid ? FETCH_IDLE : FETCH_DISCARD;
        default:       state_nxt = FETCH_IDLE;
      endcase
    end else begin
      case (state)
        FETCH_IDLE:    if (accept) state_nxt = FETCH_WAIT;
        FETCH_WAIT:    if (imem_rvalid) state_nxt = accept ? FETCH_WAIT : FETCH_IDLE;
        FETCH_DISCARD: if (imem_rvalid) state_nxt = FETCH_IDLE;
        default:       state_nxt = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FETCH_IDLE;
      pc      <= RESET_PC;
      req_npc <= '0;
    end else begin
      state <= state_nxt;
      if (redir) begin
        pc <= {redir_pc[31:2], 2'b00};
      end else if (accept) begin
        pc      <= pc + PC_STEP;
        req_npc <= pc + PC_STEP;
      end
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: behavioural imem with
// programmable latency and a scoreboard of the expected in-order fetch stream.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef INSTR_PREFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, redir, imem_req, imem_ready, imem_rvalid, out_valid, out_ready;
  logic [31:0] redir_pc, imem_addr, imem_rdata, out_ir, out_npc;

  int   n_vec = 0;
  int   n_miss = 0;
  int   n_out = 0;
  exp_t sb_q[$];

  bit          pend = 1'b0;
  int          pend_left = 0;
  logic [31:0] pend_addr = '0;
  int          lat = 1;
  bit          just_acc = 1'b0;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redir       (redir),
    .redir_pc    (redir_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_npc     (out_npc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    logic [31:0] a;
    sb_q.delete();
    a = {start[31:2], 2'b00};
    for (int i = 0; i < 256; i++) begin
      sb_q.push_back('{ir: mem_word(a), npc: a + 32'd4});
      a = a + 32'd4;
    end
  endtask

  // Called at the falling edge: present this cycle's memory response.
  task automatic cyc_begin();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (pend) begin
      if (pend_left <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_left--;
      end
    end
    #1;
  endtask

  // Sample outputs, score handshakes, record accepted requests, advance a cycle.
  task automatic cyc_end();
    exp_t e;
    #1;
    just_acc = 1'b0;
    if (rst && !redir && out_valid && out_ready) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
      check_val("out_ir", out_ir, e.ir);
      check_val("out_npc", out_npc, e.npc);
      n_out++;
    end
    if (imem_req && imem_ready) begin
      check_val("one_outstanding", 32'(pend), 32'd0);
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_left = lat;
      just_acc  = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_accept(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc_begin();
      cyc_end();
      got = just_acc;
    end
    check_val(tag, 32'(got), 32'd1);
  endtask

  initial begin
    rst = 1'b0; redir = 1'b0; redir_pc = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;
    @(negedge clk);

    // Reset values
    cyc_begin(); cyc_end();
    cyc_begin();
    check_val("rst_req", 32'(imem_req), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_ir", out_ir, 32'd0);
    check_val("rst_npc", out_npc, 32'd0);
    cyc_end();
    rst = 1'b1;
    sb_restart(RST_PC);

    // Streaming, 1-cycle memory: sequential addresses and 1 word/cycle after fill
    for (int i = 0; i < 14; i++) begin
      cyc_begin();
      check_val("fill_req", 32'(imem_req), 32'd1);
      check_val("fill_addr", imem_addr, RST_PC + 32'(4 * i));
      if (i > 0) check_val("fill_valid", 32'(out_valid), 32'(i >= 2 - BYP));
      cyc_end();
    end

    // Back-pressure: buffer fills, requests stop, nothing overwritten
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc_begin();
      if (i >= 5) check_val("stall_req", 32'(imem_req), 32'd0);
      check_val("stall_valid", 32'(out_valid), 32'd1);
      cyc_end();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc_begin();
      check_val("release_valid", 32'(out_valid), 32'd1);
      cyc_end();
    end

    // Redirect while a 3-cycle read is outstanding: stale word is discarded
    lat = 3;
    run_until_accept("wait_acc");
    cyc_begin();
    redir = 1'b1; redir_pc = 32'h0000_0103;
    sb_restart(32'h0000_0100);
    cyc_end();
    redir = 1'b0;
    lat = 1;
    cyc_begin();
    check_val("discard_valid", 32'(out_valid), 32'd0);
    check_val("discard_req", 32'(imem_req), 32'd0);
    cyc_end();
    cyc_begin();
    check_val("stale_rvalid", 32'(imem_rvalid), 32'd1);
    check_val("stale_req", 32'(imem_req), 32'd0);
    cyc_end();
    cyc_begin();
    check_val("target_req", 32'(imem_req), 32'd1);
    check_val("target_addr", imem_addr, 32'h0000_0100);
    cyc_end();
    for (int i = 0; i < 12; i++) begin cyc_begin(); cyc_end(); end

    // Redirect coinciding with rvalid and a pop
    begin
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        cyc_begin();
        if (imem_rvalid && out_valid) begin
          found = 1'b1;
          redir = 1'b1; redir_pc = 32'h0000_0200;
          sb_restart(32'h0000_0200);
        end
        cyc_end();
        redir = 1'b0;
      end
      check_val("rv_redir_found", 32'(found), 32'd1);
    end
    cyc_begin();
    check_val("rv_redir_valid", 32'(out_valid), 32'd0);
    check_val("rv_redir_req", 32'(imem_req), 32'd1);
    check_val("rv_redir_addr", imem_addr, 32'h0000_0200);
    cyc_end();
    for (int i = 0; i < 12; i++) begin cyc_begin(); cyc_end(); end

    // Reset while WAIT; stale rvalid arrives one cycle after release
    lat = 3;
    run_until_accept("rst_wait_acc");
    rst = 1'b0;
    cyc_begin();
    check_val("rst_mid_req", 32'(imem_req), 32'd0);
    cyc_end();
    rst = 1'b1; imem_ready = 1'b0; lat = 1;
    sb_restart(RST_PC);
    cyc_begin();
    check_val("post_rst_req", 32'(imem_req), 32'd1);
    check_val("post_rst_addr", imem_addr, RST_PC);
    check_val("post_rst_valid", 32'(out_valid), 32'd0);
    cyc_end();
    imem_ready = 1'b1;
    cyc_begin();
    check_val("post_rst_stale", 32'(imem_rvalid), 32'd1);
    cyc_end();
    for (int i = 0; i < 12; i++) begin cyc_begin(); cyc_end(); end

    // Mixed random traffic with occasional redirects
    for (int i = 0; i < 300; i++) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      lat        = $urandom_range(1, 3);
      cyc_begin();
      if ($urandom_range(0, 24) == 0) begin
        redir    = 1'b1;
        redir_pc = $urandom();
        sb_restart(redir_pc);
      end
      cyc_end();
      redir = 1'b0;
    end

    check_val("outputs_seen", 32'(n_out >= 150), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
